// File: rtl/frame_reader.sv
// Streams a stored frame out of a single frame buffer in step with display pixel requests.
// Latency: read strobe 1 cycle, pixel 3 cycles after pix_req; back-to-back requests accepted, no stall.
module frame_reader #(
    parameter int          IMG_W = 320,
    parameter int          IMG_H = 240,
    parameter logic [7:0]  BG    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic        pix_req,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [7:0]  rd_data,
    output logic [16:0] rd_addr,
    output logic        rd_en,
    output logic [7:0]  pix_out,
    output logic        pix_valid,
    output logic [7:0]  frame_count
);

    localparam logic [16:0] LAST_ADDR = 17'(IMG_W * IMG_H - 1);
    localparam logic [10:0] W_LIM     = 11'(IMG_W);
    localparam logic [10:0] H_LIM     = 11'(IMG_H);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM} state_t;

    state_t      state_q, state_d;
    logic [16:0] ptr_q, ptr_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic        rd_en_q, rd_en_d;
    logic [7:0]  fc_q, fc_d;
    logic        v1_q, v2_q, rd2_q;
    logic        pix_valid_q;
    logic [7:0]  pix_out_q;

    logic        sof, in_win, issue;
    logic [16:0] addr_sel;

    assign sof    = pix_req && (hcount == 10'd0) && (vcount == 10'd0);
    assign in_win = pix_req && ({1'b0, hcount} < W_LIM) && ({1'b0, vcount} < H_LIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = 1'b0;
        fc_d      = fc_q;
        issue     = 1'b0;
        addr_sel  = ptr_q;
        case (state_q)
            IDLE: begin
                if (frame_done) state_d = WAIT_SOF;
            end
            WAIT_SOF, STREAM: begin
                // SOF always restarts at pixel 0, even mid-frame
                if (sof) begin
                    issue    = 1'b1;
                    addr_sel = 17'd0;
                end else if (state_q == STREAM && in_win) begin
                    issue    = 1'b1;
                    addr_sel = ptr_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_sel;
            if (addr_sel == LAST_ADDR) begin
                state_d = WAIT_SOF;
                ptr_d   = 17'd0;
                fc_d    = fc_q + 8'd1;
            end else begin
                state_d = STREAM;
                ptr_d   = addr_sel + 17'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 17'd0;
            rd_addr_q   <= 17'd0;
            rd_en_q     <= 1'b0;
            fc_q        <= 8'd0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            rd2_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_out_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            fc_q        <= fc_d;
            // rd_en_q doubles as the in-window/read-issued flag of stage 1
            v1_q        <= pix_req;
            v2_q        <= v1_q;
            rd2_q       <= rd_en_q;
            pix_valid_q <= v2_q;
            if (v2_q) pix_out_q <= rd2_q ? rd_data : BG;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign rd_en       = rd_en_q;
    assign pix_out     = pix_out_q;
    assign pix_valid   = pix_valid_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_frame_reader.sv
// Randomized bench for frame_reader: per-request reference model predicts read strobes,
// addresses, returned pixels and the frame counter, checked every cycle.
module tb_frame_reader;

    localparam int         W    = 6;
    localparam int         H    = 3;
    localparam logic [7:0] BGV  = 8'hC3;
    localparam int         NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst, frame_done, pix_req;
    logic [9:0]  hcount, vcount;
    logic [7:0]  rd_data;
    logic [16:0] rd_addr;
    logic        rd_en;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    frame_reader #(.IMG_W(W), .IMG_H(H), .BG(BGV)) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .pix_req(pix_req),
        .hcount(hcount), .vcount(vcount), .rd_data(rd_data),
        .rd_addr(rd_addr), .rd_en(rd_en), .pix_out(pix_out),
        .pix_valid(pix_valid), .frame_count(frame_count)
    );

    logic [7:0] mem [NPIX];

    int checks = 0;
    int errors = 0;

    // model: 0 = no frame, 1 = frame held waiting for SOF, 2 = frame streaming
    int   mode    = 0;
    int   next_px = 0;
    int   exp_fc  = 0;
    int   exp_addr = 0;
    int   exp_pix  = 0;
    bit   s_rden [8];
    int   s_addr [8];
    bit   s_vld  [8];
    int   s_pix  [8];
    int   cyc = 0;
    bit   prev_rden = 1'b0;
    int   prev_addr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit q, input int h, input int v);
        int  slot;
        bit  rd;
        int  a;
        bit  sof, inw;
        @(negedge clk);
        slot = cyc % 8;
        if (s_rden[slot]) exp_addr = s_addr[slot];
        if (s_vld[slot])  exp_pix  = s_pix[slot];
        check("rd_en",       32'(rd_en),       32'(s_rden[slot]));
        check("rd_addr",     32'(rd_addr),     exp_addr);
        check("pix_valid",   32'(pix_valid),   32'(s_vld[slot]));
        check("pix_out",     32'(pix_out),     exp_pix);
        check("frame_count", 32'(frame_count), exp_fc);
        s_rden[slot] = 1'b0;
        s_vld[slot]  = 1'b0;

        // buffer returns the word addressed by last cycle's strobe; otherwise noise
        if (prev_rden && prev_addr < NPIX) rd_data = mem[prev_addr];
        else                               rd_data = 8'($urandom);
        prev_rden = rd_en;
        prev_addr = int'(rd_addr);

        rst        = r;
        frame_done = f;
        pix_req    = q;
        hcount     = 10'(h);
        vcount     = 10'(v);

        if (r) begin
            mode     = 0;
            next_px  = 0;
            exp_fc   = 0;
            exp_addr = 0;
            exp_pix  = 0;
            for (int k = 1; k <= 3; k++) begin
                s_rden[(cyc + k) % 8] = 1'b0;
                s_vld[(cyc + k) % 8]  = 1'b0;
            end
        end else begin
            rd  = 1'b0;
            a   = 0;
            sof = q && h == 0 && v == 0;
            inw = q && h < W && v < H;
            if (mode == 0) begin
                if (f) mode = 1;
            end else if (sof) begin
                rd = 1'b1;
                a  = 0;
            end else if (mode == 2 && inw) begin
                rd = 1'b1;
                a  = next_px;
            end
            if (rd) begin
                if (a == NPIX - 1) begin
                    mode   = 1;
                    exp_fc = (exp_fc + 1) % 256;
                end else begin
                    mode    = 2;
                    next_px = a + 1;
                end
            end
            s_rden[(cyc + 1) % 8] = rd;
            s_addr[(cyc + 1) % 8] = a;
            if (q) begin
                s_vld[(cyc + 3) % 8] = 1'b1;
                s_pix[(cyc + 3) % 8] = rd ? int'(mem[a]) : int'(BGV);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // raster scan of a dw x rows display, optional request gaps and stray frame_done pulses
    task automatic scan(input int dw, input int rows, input int gap_pct, input bit fd_noise);
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h < dw; h++) begin
                while ($urandom_range(99) < gap_pct)
                    step(1'b0, fd_noise && ($urandom_range(19) == 0), 1'b0, 0, 0);
                step(1'b0, fd_noise && ($urandom_range(19) == 0), 1'b1, h, v);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            s_rden[i] = 1'b0; s_addr[i] = 0; s_vld[i] = 1'b0; s_pix[i] = 0;
        end
        rst = 1'b1; frame_done = 1'b0; pix_req = 1'b0;
        hcount = 10'd0; vcount = 10'd0; rd_data = 8'd0;
        @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 0, 0);

        // no frame stored: every pixel is background, no reads
        scan(9, 5, 0, 1'b0);
        scan(9, 5, 40, 1'b0);

        // frame stored: dense scan, then gapped scan with stray frame_done
        step(1'b0, 1'b1, 1'b0, 0, 0);
        scan(9, 5, 0, 1'b1);
        scan(9, 5, 30, 1'b1);

        // SOF arrives mid-frame and restarts the readout
        scan(9, 2, 10, 1'b0);
        scan(9, 5, 0, 1'b0);

        // reset with two requests in flight, then wait for a new frame_done
        step(1'b0, 1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1, 0);
        step(1'b1, 1'b1, 1'b1, 2, 0);
        idle(4);
        scan(9, 5, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 0);

        // enough back-to-back frames to wrap frame_count
        for (int n = 0; n < 260; n++) scan(W, H, 0, 1'b0);

        // random mix of coordinates, strobes and resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(299) == 0,
                 $urandom_range(29) == 0,
                 $urandom_range(99) < 70,
                 ($urandom_range(3) == 0) ? 0 : int'($urandom_range(0, 11)),
                 ($urandom_range(3) == 0) ? 0 : int'($urandom_range(0, 5)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 320, meaning stored image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, meaning stored image height in lines.
REQ-003 SHALL have parameter BG, default 8'h00, meaning pixel value driven outside the image window.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_done  input  1  one-cycle pulse from the capture side when a full frame has been written.
REQ-007 SHALL have port pix_req  input  1  display pixel strobe; one display pixel per asserted cycle.
REQ-008 SHALL have ports hcount, vcount  input  10 each  display coordinates of the pixel requested by pix_req.
REQ-009 SHALL have port rd_data  input  8  frame buffer read data, valid the cycle after rd_en.
REQ-010 SHALL have port rd_addr  output  17  frame buffer read address.
REQ-011 SHALL have port rd_en  output  1  frame buffer read strobe.
REQ-012 SHALL have ports pix_out  output  8  and pix_valid  output  1  carrying the display pixel and its qualifier.
REQ-013 SHALL have port frame_count  output  8  count of frames fully read out since reset.

Function
REQ-014 SHALL implement states IDLE, WAIT_SOF and STREAM.
REQ-015 IDLE SHALL transition to WAIT_SOF on frame_done=1.
REQ-016 WAIT_SOF SHALL transition to STREAM on pix_req=1 with hcount=0 and vcount=0 (start of frame, SOF).
REQ-017 STREAM SHALL return to WAIT_SOF after the read of address IMG_W*IMG_H-1 has been issued.
REQ-018 In STREAM, a pix_req with hcount<IMG_W and vcount<IMG_H is "in window".
REQ-019 In STREAM, an in-window pix_req SHALL issue a read: rd_en=1 and rd_addr=current address in the next cycle, after which the address SHALL increment by 1.
REQ-020 The SOF pixel itself SHALL be read at address 0: the address SHALL be loaded to 0 on SOF and pixel (0,0) SHALL issue the read of address 0 in the same pipeline slot.
REQ-021 rd_en SHALL be exactly one cycle wide per in-window pix_req and 0 in all other cycles.
REQ-022 rd_addr SHALL hold its last value when rd_en=0.
REQ-023 rd_addr SHALL never exceed IMG_W*IMG_H-1; in-window requests beyond that address SHALL issue no read.
REQ-024 Every pix_req in any state SHALL produce exactly one pix_valid=1 cycle 3 cycles later (request cycle N, response cycle N+3), with requests in order.
REQ-025 For a request that issued a read, pix_out SHALL equal rd_data sampled in cycle N+2.
REQ-026 For any other request (out of window, state IDLE or WAIT_SOF, or address exhausted), pix_out SHALL equal BG.
REQ-027 The in-window flag SHALL be carried through the pipeline alongside the request.
REQ-028 pix_valid SHALL be 0 when no request is in flight; pix_out SHALL hold its last value when pix_valid=0.
REQ-029 The pipeline SHALL accept back-to-back pix_req (every cycle) without stalls.
REQ-030 frame_count SHALL increment by 1, wrapping 255->0, in the cycle STREAM exits on the final address.
REQ-031 frame_done while in WAIT_SOF or STREAM SHALL be ignored: single buffer, no state change.
REQ-032 SOF seen while in STREAM (frame readout incomplete) SHALL reload the address to 0 and restart the frame, with no frame_count increment.

Reset
REQ-033 When rst=1 at a clock edge, state SHALL become IDLE and rd_addr=0, rd_en=0, pix_out=0, pix_valid=0, frame_count=0.
REQ-034 When rst=1, all in-flight pipeline requests SHALL be discarded.
REQ-035 Reset SHALL take priority over frame_done, pix_req and SOF in the same cycle.
REQ-036 After rst deasserts, the block SHALL wait in IDLE for a new frame_done.

Verification
REQ-037 No frame_done, full 640x480 scan -> rd_en never 1; every pix_valid carries pix_out=8'h00.
REQ-038 frame_done, then scan with rd_data=rd_addr[7:0] -> pixel (0,0) yields rd_addr=0 at N+1 and pix_out=0x00 at N+3; pixel (319,0) yields addr 319; pixel (0,1) yields addr 320; pixel (320,0) yields BG with no rd_en.
REQ-039 Full frame with IMG_W=4, IMG_H=2 -> addresses 0..7 each exactly once; frame_count 0->1; next SOF restarts at address 0.
REQ-040 SOF at (0,0) while in STREAM at address 100 -> next read at address 0; frame_count unchanged.
REQ-041 rst asserted for one cycle with 2 requests in flight -> no pix_valid afterwards; all outputs 0; IDLE until a new frame_done.
REQ-042 frame_count at 255, one more complete frame -> frame_count=0.
